cpu_run_ctrl: RTL and testbench

Execution sequencer for the single-cycle CPU on the FPGA board. It generates clk_cpu from the board clock and supports four modes: free run, single step, N-cycle burst, and run-until-breakpoint on the CPU's PC. It sits between the board switches/buttons and the CPU, replacing the plain run/step clock mux in the debug unit. It exposes halt status and breakpoint status to the LED/display logic.

---
 rtl/cpu_run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer for the single-cycle CPU: generates clk_cpu for free run, single step, N-cycle burst and run-until-breakpoint.
// Optional build macro CPU_CYCLE_COUNT_EN adds a 32-bit count of issued CPU cycles on cyc_cnt.
module cpu_run_ctrl #(
  parameter int BURST_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               go,
  input  logic [BURST_W-1:0] burst_n,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               clk_cpu,
  output logic               busy,
  output logic               bp_hit,
  output logic [2:0]         state,
  output logic [31:0]        cyc_cnt
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_STEP  = 3'd1,
    S_RUN   = 3'd2,
    S_BURST = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  // Stage 0 takes the raw {go, step, run}; the last stage is the usable value.
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic                        r_step_prev;
  logic                        r_go_prev;

  state_t             r_state;
  logic               r_clk_cpu;
  logic               r_busy;
  logic               r_bp_hit;
  logic               r_skip;
  logic [BURST_W-1:0] r_remaining;

  logic w_run_s;
  logic w_step_s;
  logic w_go_s;
  logic w_step_edge;
  logic w_go_edge;
  logic w_tick;
  logic w_bp;
  logic w_pulse_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {go, step, run}};
    end
  end

  assign w_run_s     = r_sync[SYNC_STAGES-1][0];
  assign w_step_s    = r_sync[SYNC_STAGES-1][1];
  assign w_go_s      = r_sync[SYNC_STAGES-1][2];
  assign w_step_edge = w_step_s & ~r_step_prev;
  assign w_go_edge   = w_go_s & ~r_go_prev;

  // A new pulse may only start on a clk where clk_cpu is low, which also gives the 2-clk minimum period.
  assign w_tick = ~r_clk_cpu;
  assign w_bp   = bp_en && (pc == bp_addr) && !r_skip;

  always_comb begin
    w_pulse_start = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_STEP:  w_pulse_start = 1'b1;
        S_RUN:   w_pulse_start = w_run_s && !w_bp;
        S_BURST: w_pulse_start = (r_remaining != '0) && !w_step_edge && !w_bp;
        default: w_pulse_start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_prev <= 1'b0;
      r_go_prev   <= 1'b0;
      r_state     <= S_HALT;
      r_clk_cpu   <= 1'b0;
      r_busy      <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_skip      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_step_prev <= w_step_s;
      r_go_prev   <= w_go_s;

      if (w_pulse_start) begin
        r_clk_cpu <= 1'b1;
        r_skip    <= 1'b0;
      end else begin
        r_clk_cpu <= 1'b0;
      end

      case (r_state)
        S_HALT: begin
          if (w_run_s) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_step_edge) begin
            r_state  <= S_STEP;
            r_busy   <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_go_edge && (burst_n != '0)) begin
            r_state     <= S_BURST;
            r_busy      <= 1'b1;
            r_skip      <= 1'b1;
            r_bp_hit    <= 1'b0;
            r_remaining <= burst_n;
          end
        end

        S_STEP: begin
          if (r_clk_cpu) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
          end
        end

        S_RUN: begin
          if (w_tick && !w_run_s) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
          end else if (w_tick && w_bp) begin
            r_state  <= S_BRK;
            r_busy   <= 1'b0;
            r_bp_hit <= 1'b1;
          end
        end

        S_BURST: begin
          if (w_step_edge) begin
            r_remaining <= '0;
          end
          if (w_tick) begin
            if (w_step_edge || (r_remaining == '0)) begin
              r_state <= S_HALT;
              r_busy  <= 1'b0;
            end else if (w_bp) begin
              r_state     <= S_BRK;
              r_busy      <= 1'b0;
              r_bp_hit    <= 1'b1;
              r_remaining <= '0;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end
        end

        S_BRK: begin
          if (!w_run_s) begin
            r_state <= S_HALT;
          end
        end

        default: begin
          r_state <= S_HALT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_CYCLE_COUNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= '0;
    end else if (w_pulse_start) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`else
  assign cyc_cnt = '0;
`endif

  assign clk_cpu = r_clk_cpu;
  assign busy    = r_busy;
  assign bp_hit  = r_bp_hit;
  assign state   = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a PC model advances 4 per CPU pulse; expected pulse PCs are queued by the stimulus and popped by a monitor.
module tb_cpu_run_ctrl;

  localparam int BW = 16;
`ifdef CPU_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          run     = 1'b0;
  logic          step    = 1'b0;
  logic          go      = 1'b0;
  logic [BW-1:0] burst_n = '0;
  logic          bp_en   = 1'b0;
  logic [31:0]   bp_addr = '0;
  logic [31:0]   pc;
  logic          clk_cpu;
  logic          busy;
  logic          bp_hit;
  logic [2:0]    state;
  logic [31:0]   cyc_cnt;

  cpu_run_ctrl #(.BURST_W(BW), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .step    (step),
    .go      (go),
    .burst_n (burst_n),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .pc      (pc),
    .clk_cpu (clk_cpu),
    .busy    (busy),
    .bp_hit  (bp_hit),
    .state   (state),
    .cyc_cnt (cyc_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          pulses  = 0;
  int          pc_mark = 0;
  logic [31:0] pc_base = '0;
  logic [31:0] exp_q[$];
  bit          strict     = 1'b1;
  bit          chk_period = 1'b0;

  // CPU PC model: the PC presented is the instruction the next pulse will execute.
  assign pc = pc_base + 32'(4 * (pulses - pc_mark));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one CPU cycle per rising clk_cpu seen at a clk falling edge.
  int   cyc       = 0;
  int   last_rise = 0;
  bit   in_period = 1'b0;
  logic prev_clk  = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (clk_cpu === 1'b1) begin
      chk("high_phase_len", 32'(prev_clk), 32'd0);
      if (prev_clk !== 1'b1) begin
        $display("pulse #%0d pc=0x%08h state=%0d", pulses + 1, pc, state);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pulse_pc", pc, e);
        end else if (strict) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got pulse at pc=0x%08h, expected none", pc);
        end
        if (chk_period && in_period)
          chk("run_period", 32'(cyc - last_rise), 32'd2);
        in_period = chk_period;
        last_rise = cyc;
        pulses++;
      end
    end
    prev_clk = clk_cpu;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_q_empty(input int max, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < max) begin
      tick(1);
      i++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    int          i;
    logic [31:0] c0;

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_clk_cpu", 32'(clk_cpu), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_cyc_cnt", cyc_cnt, 32'd0);

    // 1: single step, 3-clk button press
    pc_base = 32'h100;
    pc_mark = pulses;
    p0 = pulses;
    exp_q.push_back(32'h100);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    tick(1);
    chk("step_latency", 32'(pulses - p0), 32'd1);
    tick(4);
    chk("step_count", 32'(pulses - p0), 32'd1);
    chk("step_state", 32'(state), 32'd0);
    chk("step_busy", 32'(busy), 32'd0);
    chk("step_cyc_cnt", cyc_cnt, CNT_EN ? 32'd1 : 32'd0);

    // 2: free run for 40 clk
    p0 = pulses;
    c0 = cyc_cnt;
    strict = 1'b0;
    chk_period = 1'b1;
    run = 1'b1;
    tick(3);
    chk("run_busy_on", 32'(busy), 32'd1);
    tick(37);
    run = 1'b0;
    tick(6);
    chk_period = 1'b0;
    strict = 1'b1;
    chk("run_state", 32'(state), 32'd0);
    chk("run_busy_off", 32'(busy), 32'd0);
    chk("run_pulses_min", 32'(pulses - p0 >= 18), 32'd1);
    chk("run_pulses_max", 32'(pulses - p0 <= 21), 32'd1);
    chk("run_cyc_cnt", cyc_cnt - c0, CNT_EN ? 32'(pulses - p0) : 32'd0);

    // 3: burst of 5, then a zero-length burst
    pc_base = 32'h200;
    pc_mark = pulses;
    p0 = pulses;
    c0 = cyc_cnt;
    for (int k = 0; k < 5; k++) exp_q.push_back(32'h200 + 32'(4 * k));
    burst_n = 16'd5;
    go = 1'b1;
    tick(3);
    go = 1'b0;
    wait_q_empty(30, "burst5_done");
    tick(6);
    chk("burst5_count", 32'(pulses - p0), 32'd5);
    chk("burst5_state", 32'(state), 32'd0);
    chk("burst5_cyc_cnt", cyc_cnt - c0, CNT_EN ? 32'd5 : 32'd0);
    p0 = pulses;
    burst_n = 16'd0;
    go = 1'b1;
    tick(3);
    go = 1'b0;
    tick(10);
    chk("burst0_count", 32'(pulses - p0), 32'd0);
    chk("burst0_state", 32'(state), 32'd0);
    chk("burst0_busy", 32'(busy), 32'd0);

    // 4: breakpoint at 0xC with PC starting at 0
    bp_en = 1'b1;
    bp_addr = 32'h0000_000C;
    pc_base = 32'h0;
    pc_mark = pulses;
    p0 = pulses;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    run = 1'b1;
    i = 0;
    while (state !== 3'd4 && i < 40) begin
      tick(1);
      i++;
    end
    tick(2);
    chk("bp_state", 32'(state), 32'd4);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_count", 32'(pulses - p0), 32'd3);
    run = 1'b0;
    tick(6);
    chk("brk_exit_state", 32'(state), 32'd0);
    chk("bp_hit_sticky", 32'(bp_hit), 32'd1);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    run = 1'b1;
    wait_q_empty(30, "bp_resume_done");
    chk("resume_bp_hit", 32'(bp_hit), 32'd0);
    chk("resume_state", 32'(state), 32'd2);
    strict = 1'b0;
    run = 1'b0;
    tick(8);
    chk("resume_halt", 32'(state), 32'd0);
    exp_q.delete();
    strict = 1'b1;
    bp_en = 1'b0;

    // 5: burst of 100 aborted by a step after 10 pulses
    strict = 1'b0;
    p0 = pulses;
    burst_n = 16'd100;
    go = 1'b1;
    tick(3);
    go = 1'b0;
    i = 0;
    while (pulses - p0 < 10 && i < 60) begin
      tick(1);
      i++;
    end
    step = 1'b1;
    tick(3);
    step = 1'b0;
    tick(6);
    chk("abort_count_min", 32'(pulses - p0 >= 10), 32'd1);
    chk("abort_count_max", 32'(pulses - p0 <= 11), 32'd1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_remaining", 32'(dut.r_remaining), 32'd0);
    tick(6);
    chk("abort_no_more", 32'(pulses - p0 <= 11), 32'd1);

    // 6: reset in the middle of a high phase
    run = 1'b1;
    i = 0;
    while (clk_cpu !== 1'b1 && i < 20) begin
      tick(1);
      i++;
    end
    tick(2);
    chk("pre_rst_clk_cpu", 32'(clk_cpu), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_clk_cpu", 32'(clk_cpu), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cyc_cnt", cyc_cnt, 32'd0);
    run = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
